// File: rtl/fpc_rr_tag_sched_pkg.sv
// Shared constants and tag helpers for the read-request tag scheduler.
package fpc_rr_pkg;

  localparam int NCHAN     = 4;
  localparam int TAG_W     = 8;
  localparam int TAG_IDX_W = 5;

  function automatic logic [TAG_IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] tag);
    return {tag[4:3], tag[2:0]};
  endfunction

  function automatic logic tag_malformed(input logic [TAG_W-1:0] tag);
    return |tag[7:5];
  endfunction

endpackage

// File: rtl/fpc_rr_tag_sched_if.sv
// Snooped mux-issue handshake and completion stream seen by the tag scheduler.
interface fpc_rr_tag_sched_if;
  import fpc_rr_pkg::*;

  logic             rrm_valid;
  logic             rrm_ready;
  logic [TAG_W-1:0] rrm_tag;
  logic             cpl_valid;
  logic [TAG_W-1:0] cpl_tag;
  logic             cpl_last;

  modport master (
    output rrm_valid, rrm_ready, rrm_tag,
    output cpl_valid, cpl_tag, cpl_last
  );

  modport slave (
    input rrm_valid, rrm_ready, rrm_tag,
    input cpl_valid, cpl_tag, cpl_last
  );
endinterface

// File: rtl/fpc_rr_tag_sched_scoreboard.sv
// In-flight tag bitmap with outstanding count, per-channel idle flags and
// sticky first-error capture.
module fpc_tag_scoreboard
  import fpc_rr_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 set_valid,
  input  logic [TAG_W-1:0]     set_tag,
  input  logic                 clr_valid,
  input  logic [TAG_W-1:0]     clr_tag,
  output logic [31:0]          busy,
  output logic [5:0]           count,
  output logic [NCHAN-1:0]     chan_idle,
  output logic                 err,
  output logic [TAG_W-1:0]     err_tag,
  output logic                 freed
);

  logic [31:0]      busy_r,  busy_next_s;
  logic [5:0]       count_r, count_next_s;
  logic [NCHAN-1:0] idle_r,  idle_next_s;
  logic             err_r,   err_next_s;
  logic [TAG_W-1:0] err_tag_r, err_tag_next_s;
  logic             set_dup_s, clr_bad_s, do_set_s, do_clr_s;

  // Next-state computation for bitmap, count, idle flags and error capture.
  always_comb begin
    set_dup_s      = set_valid && busy_r[tag_idx(set_tag)];
    clr_bad_s      = clr_valid && (tag_malformed(clr_tag) || !busy_r[tag_idx(clr_tag)]);
    do_set_s       = set_valid && !set_dup_s;
    do_clr_s       = clr_valid && !clr_bad_s;
    busy_next_s    = busy_r;
    count_next_s   = count_r;
    err_next_s     = err_r;
    err_tag_next_s = err_tag_r;
    idle_next_s    = {NCHAN{1'b1}};

    if (do_clr_s) begin
      busy_next_s[tag_idx(clr_tag)] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (do_set_s) begin
      busy_next_s[tag_idx(set_tag)] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end

    // Simultaneous issue and free cancel out in the count.
    if (do_set_s && !do_clr_s) begin
      count_next_s = (count_r == 6'd32) ? count_r : count_r + 6'd1;
    end else if (do_clr_s && !do_set_s) begin
      count_next_s = (count_r == 6'd0) ? count_r : count_r - 6'd1;
    end else begin
      count_next_s = count_r;
    end

    if (!err_r && set_dup_s) begin
      err_next_s     = 1'b1;
      err_tag_next_s = set_tag;
    end else if (!err_r && clr_bad_s) begin
      err_next_s     = 1'b1;
      err_tag_next_s = clr_tag;
    end else begin
      err_next_s     = err_r;
      err_tag_next_s = err_tag_r;
    end

    for (int n = 0; n < NCHAN; n++) begin
      idle_next_s[n] = ~|busy_next_s[8*n +: 8];
    end
  end

  // State registers; reset drops all tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r    <= 32'd0;
      count_r   <= 6'd0;
      idle_r    <= {NCHAN{1'b1}};
      err_r     <= 1'b0;
      err_tag_r <= 8'd0;
    end else begin
      busy_r    <= busy_next_s;
      count_r   <= count_next_s;
      idle_r    <= idle_next_s;
      err_r     <= err_next_s;
      err_tag_r <= err_tag_next_s;
    end
  end

  assign busy      = busy_r;
  assign count     = count_r;
  assign chan_idle = idle_r;
  assign err       = err_r;
  assign err_tag   = err_tag_r;
  assign freed     = do_clr_s;

endmodule

// File: rtl/fpc_rr_tag_sched.sv
// Read-request admission scheduler: per-channel tag gating and global
// outstanding limit. Optional stats counters under FPC_RR_STATS_EN.
module fpc_rr_tag_sched
  import fpc_rr_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCHAN-1:0]        chan_enable,
  input  logic [NCHAN-1:0]        rr_valid,
  input  logic [3*NCHAN-1:0]      rr_la_lsb,
  output logic [NCHAN-1:0]        rr_valid_gated,
  fpc_rr_tag_sched_if.slave       bus,
  output logic [5:0]              outstanding,
  output logic [31:0]             tag_busy,
  output logic [NCHAN-1:0]        chan_idle,
  output logic                    err_cpl,
  output logic [TAG_W-1:0]        err_tag
`ifdef FPC_RR_STATS_EN
  ,
  output logic [127:0]            stat_issued,
  output logic [127:0]            stat_done
`endif
);

  logic             issue_s, cpl_end_s, freed_s, room_s;
  logic [NCHAN-1:0] gate_r, gate_next_s;

  assign issue_s   = bus.rrm_valid && bus.rrm_ready;
  assign cpl_end_s = bus.cpl_valid && bus.cpl_last;

  fpc_tag_scoreboard u_sb (
    .clock     (clock),
    .reset     (reset),
    .set_valid (issue_s),
    .set_tag   (bus.rrm_tag),
    .clr_valid (cpl_end_s),
    .clr_tag   (bus.cpl_tag),
    .busy      (tag_busy),
    .count     (outstanding),
    .chan_idle (chan_idle),
    .err       (err_cpl),
    .err_tag   (err_tag),
    .freed     (freed_s)
  );

  // Admission decision uses the current bitmap; the mux's revisit spacing
  // covers the one-cycle lag, so no in-flight reservation is kept.
  always_comb begin
    room_s      = (outstanding < 6'(MAX_OUTSTANDING));
    gate_next_s = {NCHAN{1'b0}};
    for (int n = 0; n < NCHAN; n++) begin
      gate_next_s[n] = rr_valid[n] && chan_enable[n] && room_s &&
                       !tag_busy[{n[1:0], rr_la_lsb[3*n +: 3]}];
    end
  end

  // Registered gate outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      gate_r <= {NCHAN{1'b0}};
    end else begin
      gate_r <= gate_next_s;
    end
  end

  assign rr_valid_gated = gate_r;

`ifdef FPC_RR_STATS_EN
  logic [127:0] issued_r, done_r;

  // Per-channel wrapping issue/free counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_r <= 128'd0;
      done_r   <= 128'd0;
    end else begin
      for (int n = 0; n < NCHAN; n++) begin
        if (issue_s && (bus.rrm_tag[4:3] == n[1:0])) begin
          issued_r[32*n +: 32] <= issued_r[32*n +: 32] + 32'd1;
        end
        if (freed_s && (bus.cpl_tag[4:3] == n[1:0])) begin
          done_r[32*n +: 32] <= done_r[32*n +: 32] + 32'd1;
        end
      end
    end
  end

  assign stat_issued = issued_r;
  assign stat_done   = done_r;
`endif

endmodule

// File: tb/tb_fpc_rr_tag_sched.sv
// Directed self-checking bench for fpc_rr_tag_sched (MAX_OUTSTANDING=2).
module tb_fpc_rr_tag_sched;

  logic        clock;
  logic        reset;
  logic [3:0]  chan_enable;
  logic [3:0]  rr_valid;
  logic [11:0] rr_la_lsb;
  logic [3:0]  rr_valid_gated;
  logic [5:0]  outstanding;
  logic [31:0] tag_busy;
  logic [3:0]  chan_idle;
  logic        err_cpl;
  logic [7:0]  err_tag;
`ifdef FPC_RR_STATS_EN
  logic [127:0] stat_issued;
  logic [127:0] stat_done;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  fpc_rr_tag_sched_if bus ();

  fpc_rr_tag_sched #(.MAX_OUTSTANDING(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .chan_enable    (chan_enable),
    .rr_valid       (rr_valid),
    .rr_la_lsb      (rr_la_lsb),
    .rr_valid_gated (rr_valid_gated),
    .bus            (bus),
    .outstanding    (outstanding),
    .tag_busy       (tag_busy),
    .chan_idle      (chan_idle),
    .err_cpl        (err_cpl),
    .err_tag        (err_tag)
`ifdef FPC_RR_STATS_EN
    ,
    .stat_issued    (stat_issued),
    .stat_done      (stat_done)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [7:0] tag);
    bus.rrm_valid = 1'b1;
    bus.rrm_ready = 1'b1;
    bus.rrm_tag   = tag;
    tick();
    bus.rrm_valid = 1'b0;
    bus.rrm_ready = 1'b0;
  endtask

  task automatic complete(input logic [7:0] tag, input logic last);
    bus.cpl_valid = 1'b1;
    bus.cpl_tag   = tag;
    bus.cpl_last  = last;
    tick();
    bus.cpl_valid = 1'b0;
    bus.cpl_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tests_run++;
    if (tag_busy !== 32'd0 || outstanding !== 6'd0 || rr_valid_gated !== 4'h0 ||
        chan_idle !== 4'hF || err_cpl !== 1'b0 || err_tag !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset: busy=%h out=%0d gated=%h idle=%h err=%b tag=%h, want 0/0/0/F/0/00",
               tag_busy, outstanding, rr_valid_gated, chan_idle, err_cpl, err_tag);
    end
  endtask

  task automatic test_gate_issue();
    rr_valid  = 4'h1;
    rr_la_lsb = 12'h003;
    tick();
    tests_run++;
    if (rr_valid_gated !== 4'h1) begin
      tests_failed++;
      $display("FAIL gate_open: gated=%h want 1", rr_valid_gated);
    end
    issue(8'h03);
    tests_run++;
    if (tag_busy !== 32'h0000_0008 || outstanding !== 6'd1 || chan_idle !== 4'hE) begin
      tests_failed++;
      $display("FAIL issue_03: busy=%h out=%0d idle=%h want 00000008/1/E",
               tag_busy, outstanding, chan_idle);
    end
    tick();
    tests_run++;
    if (rr_valid_gated !== 4'h0) begin
      tests_failed++;
      $display("FAIL gate_busy: gated=%h want 0", rr_valid_gated);
    end
  endtask

  task automatic test_cpl_last();
    complete(8'h03, 1'b0);
    tests_run++;
    if (tag_busy !== 32'h0000_0008 || outstanding !== 6'd1) begin
      tests_failed++;
      $display("FAIL cpl_nolast: busy=%h out=%0d want 00000008/1", tag_busy, outstanding);
    end
    complete(8'h03, 1'b1);
    tests_run++;
    if (tag_busy !== 32'd0 || outstanding !== 6'd0 || chan_idle !== 4'hF || rr_valid_gated !== 4'h0) begin
      tests_failed++;
      $display("FAIL cpl_last: busy=%h out=%0d idle=%h gated=%h want 0/0/F/0",
               tag_busy, outstanding, chan_idle, rr_valid_gated);
    end
    tick();
    tests_run++;
    if (rr_valid_gated !== 4'h1) begin
      tests_failed++;
      $display("FAIL gate_reopen: gated=%h want 1", rr_valid_gated);
    end
  endtask

  task automatic test_max_outstanding();
    rr_valid  = 4'hF;
    rr_la_lsb = 12'h688;
    issue(8'h00);
    issue(8'h09);
    tests_run++;
    if (outstanding !== 6'd2 || tag_busy !== 32'h0000_0201) begin
      tests_failed++;
      $display("FAIL max_issue: out=%0d busy=%h want 2/00000201", outstanding, tag_busy);
    end
    tick();
    tests_run++;
    if (rr_valid_gated !== 4'h0) begin
      tests_failed++;
      $display("FAIL max_block: gated=%h want 0", rr_valid_gated);
    end
    complete(8'h09, 1'b1);
    tick();
    tests_run++;
    if (outstanding !== 6'd1 || rr_valid_gated !== 4'hE) begin
      tests_failed++;
      $display("FAIL max_reopen: out=%0d gated=%h want 1/E", outstanding, rr_valid_gated);
    end
  endtask

  task automatic test_same_cycle();
    issue(8'h11);
    tests_run++;
    if (outstanding !== 6'd2 || tag_busy !== 32'h0002_0001) begin
      tests_failed++;
      $display("FAIL pre_same: out=%0d busy=%h want 2/00020001", outstanding, tag_busy);
    end
    bus.rrm_valid = 1'b1;
    bus.rrm_ready = 1'b1;
    bus.rrm_tag   = 8'h1A;
    bus.cpl_valid = 1'b1;
    bus.cpl_tag   = 8'h00;
    bus.cpl_last  = 1'b1;
    tick();
    bus.rrm_valid = 1'b0;
    bus.rrm_ready = 1'b0;
    bus.cpl_valid = 1'b0;
    bus.cpl_last  = 1'b0;
    tests_run++;
    if (outstanding !== 6'd2 || tag_busy !== 32'h0402_0000 || chan_idle !== 4'h3) begin
      tests_failed++;
      $display("FAIL same_cycle: out=%0d busy=%h idle=%h want 2/04020000/3",
               outstanding, tag_busy, chan_idle);
    end
  endtask

  task automatic test_chan_disable();
    chan_enable = 4'hB;
    rr_la_lsb   = 12'h608;
    complete(8'h1A, 1'b1);
    tick();
    tests_run++;
    if (rr_valid_gated !== 4'hB || chan_idle !== 4'hB || outstanding !== 6'd1) begin
      tests_failed++;
      $display("FAIL disable_gate: gated=%h idle=%h out=%0d want B/B/1",
               rr_valid_gated, chan_idle, outstanding);
    end
    complete(8'h11, 1'b1);
    tick();
    tests_run++;
    if (chan_idle !== 4'hF || tag_busy !== 32'd0 || outstanding !== 6'd0 || rr_valid_gated !== 4'hB) begin
      tests_failed++;
      $display("FAIL disable_drain: idle=%h busy=%h out=%0d gated=%h want F/0/0/B",
               chan_idle, tag_busy, outstanding, rr_valid_gated);
    end
    chan_enable = 4'hF;
    rr_valid    = 4'h0;
  endtask

  task automatic test_err();
    complete(8'h05, 1'b1);
    tests_run++;
    if (err_cpl !== 1'b1 || err_tag !== 8'h05 || outstanding !== 6'd0) begin
      tests_failed++;
      $display("FAIL err_first: err=%b tag=%h out=%0d want 1/05/0", err_cpl, err_tag, outstanding);
    end
    complete(8'h20, 1'b1);
    tests_run++;
    if (err_cpl !== 1'b1 || err_tag !== 8'h05) begin
      tests_failed++;
      $display("FAIL err_sticky: err=%b tag=%h want 1/05", err_cpl, err_tag);
    end
  endtask

  task automatic test_dup_issue();
    issue(8'h03);
    issue(8'h03);
    tests_run++;
    if (outstanding !== 6'd1 || tag_busy !== 32'h0000_0008 || err_tag !== 8'h05) begin
      tests_failed++;
      $display("FAIL dup_issue: out=%0d busy=%h tag=%h want 1/00000008/05",
               outstanding, tag_busy, err_tag);
    end
    complete(8'h03, 1'b1);
    tests_run++;
    if (outstanding !== 6'd0 || tag_busy !== 32'd0) begin
      tests_failed++;
      $display("FAIL dup_drain: out=%0d busy=%h want 0/0", outstanding, tag_busy);
    end
  endtask

  task automatic test_reset_mid();
    issue(8'h03);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (tag_busy !== 32'd0 || outstanding !== 6'd0 || err_cpl !== 1'b0 || err_tag !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%h out=%0d err=%b tag=%h want 0/0/0/00",
               tag_busy, outstanding, err_cpl, err_tag);
    end
    complete(8'h03, 1'b1);
    tests_run++;
    if (err_cpl !== 1'b1 || err_tag !== 8'h03 || outstanding !== 6'd0) begin
      tests_failed++;
      $display("FAIL stale_cpl: err=%b tag=%h out=%0d want 1/03/0", err_cpl, err_tag, outstanding);
    end
  endtask

`ifdef FPC_RR_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue(8'h08);
    issue(8'h09);
    complete(8'h08, 1'b1);
    complete(8'h09, 1'b1);
    issue(8'h0A);
    complete(8'h0A, 1'b1);
    tick();
    tests_run++;
    if (stat_issued[63:32] !== 32'd3 || stat_done[63:32] !== 32'd3 ||
        stat_issued[31:0] !== 32'd0 || stat_done[127:64] !== 64'd0) begin
      tests_failed++;
      $display("FAIL stats: issued=%0d done=%0d want 3/3 (other lanes 0)",
               stat_issued[63:32], stat_done[63:32]);
    end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    chan_enable   = 4'hF;
    rr_valid      = 4'h0;
    rr_la_lsb     = 12'h000;
    bus.rrm_valid = 1'b0;
    bus.rrm_ready = 1'b0;
    bus.rrm_tag   = 8'h00;
    bus.cpl_valid = 1'b0;
    bus.cpl_tag   = 8'h00;
    bus.cpl_last  = 1'b0;

    test_reset();
    test_gate_issue();
    test_cpl_last();
    test_max_outstanding();
    test_same_cycle();
    test_chan_disable();
    test_err();
    test_dup_issue();
    test_reset_mid();
`ifdef FPC_RR_STATS_EN
    test_stats();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
